// File: rtl/q2_sequencer.sv
// Instruction-cycle sequencer: two-phase states (ws marks phase 1), a bit-serial
// ALU window of 8 write strobes, and run/step control evaluated only at FETCH phase 0.
module q2_sequencer (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic step,
   input  logic deref,
   input  logic o0,
   input  logic o1,
   input  logic o2,
   output logic s0,
   output logic s1,
   output logic s2,
   output logic s3,
   output logic ws,
   output logic running
);

   typedef enum logic [3:0] {
      ST_FETCH    = 4'b0000,
      ST_DEREF    = 4'b0001,
      ST_LOAD     = 4'b0010,
      ST_EXEC     = 4'b0011,
      ST_ALU      = 4'b0100,
      ST_ALU_LAST = 4'b1100
   } state_t;

   state_t     r_state;
   state_t     w_state_next;
   logic       r_phase;
   logic       w_phase_next;
   logic [2:0] r_cnt;
   logic [2:0] w_cnt_next;
   logic       r_pend;
   logic       w_pend_next;
   logic       r_deref;
   logic [2:0] r_op;
   logic       w_sample;
   logic       w_unused_op;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_FETCH;
         r_phase <= 1'b0;
         r_cnt   <= 3'd0;
         r_pend  <= 1'b0;
         r_deref <= 1'b0;
         r_op    <= 3'd0;
      end else begin
         r_state <= w_state_next;
         r_phase <= w_phase_next;
         r_cnt   <= w_cnt_next;
         r_pend  <= w_pend_next;
         if (w_sample) begin
            r_deref <= deref;
            r_op    <= {o2, o1, o0};
         end
      end
   end

   // Only the ALU/non-ALU selector steers sequencing; o0/o1 ride along with the sample.
   assign w_unused_op = ^r_op[1:0];

   always_comb begin
      w_state_next = r_state;
      w_phase_next = r_phase;
      w_cnt_next   = r_cnt;
      w_pend_next  = r_pend | step;
      w_sample     = 1'b0;
      case (r_state)
         ST_FETCH: begin
            if (!r_phase) begin
               // A step arriving on the same edge as the clear merges with the one consumed.
               if (run || r_pend) begin
                  w_phase_next = 1'b1;
                  w_pend_next  = 1'b0;
               end
            end else begin
               w_phase_next = 1'b0;
               w_sample     = 1'b1;
               if (deref)
                  w_state_next = ST_DEREF;
               else if (!o2)
                  w_state_next = ST_LOAD;
               else
                  w_state_next = ST_EXEC;
            end
         end
         ST_DEREF: begin
            w_phase_next = ~r_phase;
            if (r_phase)
               w_state_next = r_op[2] ? ST_EXEC : ST_LOAD;
         end
         ST_LOAD: begin
            w_phase_next = ~r_phase;
            if (r_phase) begin
               w_state_next = ST_ALU;
               w_cnt_next   = 3'd0;
            end
         end
         ST_ALU: begin
            w_phase_next = ~r_phase;
            if (r_phase) begin
               w_cnt_next = r_cnt + 3'd1;
               if (r_cnt == 3'd6)
                  w_state_next = ST_ALU_LAST;
            end
         end
         ST_ALU_LAST: begin
            w_phase_next = ~r_phase;
            if (r_phase)
               w_state_next = ST_EXEC;
         end
         ST_EXEC: begin
            w_phase_next = ~r_phase;
            if (r_phase)
               w_state_next = ST_FETCH;
         end
         default: begin
            w_state_next = ST_FETCH;
            w_phase_next = 1'b0;
         end
      endcase
   end

   assign {s3, s2, s1, s0} = r_state;
   assign ws               = r_phase;
   // Reset forces running low even if run is held high.
   assign running = ~rst & (run | r_phase | (r_state != ST_FETCH));

endmodule

// File: tb/tb_q2_sequencer.sv
// Scoreboard bench for q2_sequencer: expected per-cycle {state, ws, running} traces are
// queued as stimulus is planned and popped one per clock as the DUT advances.
module tb_q2_sequencer;

   logic clk = 1'b0;
   logic rst, run, step, deref, o0, o1, o2;
   logic s0, s1, s2, s3, ws, running;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [3:0] s;
      logic       ws;
      logic       rn;
   } obs_t;

   obs_t sb[$];

   localparam logic [3:0] FETCH    = 4'b0000;
   localparam logic [3:0] DEREF    = 4'b0001;
   localparam logic [3:0] LOAD     = 4'b0010;
   localparam logic [3:0] EXEC     = 4'b0011;
   localparam logic [3:0] ALU      = 4'b0100;
   localparam logic [3:0] ALU_LAST = 4'b1100;

   q2_sequencer dut (
      .clk(clk), .rst(rst), .run(run), .step(step), .deref(deref),
      .o0(o0), .o1(o1), .o2(o2),
      .s0(s0), .s1(s1), .s2(s2), .s3(s3), .ws(ws), .running(running)
   );

   always #5 clk = ~clk;

   task automatic push(input logic [3:0] s, input logic w, input logic r);
      sb.push_back(obs_t'({s, w, r}));
   endtask

   // Expected trace of one instruction; run_first is the running level in FETCH phase 0.
   task automatic push_instr(input logic o2_v, input logic deref_v, input logic run_first);
      push(FETCH, 1'b0, run_first);
      push(FETCH, 1'b1, 1'b1);
      if (deref_v) begin
         push(DEREF, 1'b0, 1'b1);
         push(DEREF, 1'b1, 1'b1);
      end
      if (!o2_v) begin
         push(LOAD, 1'b0, 1'b1);
         push(LOAD, 1'b1, 1'b1);
         for (int k = 0; k < 7; k++) begin
            push(ALU, 1'b0, 1'b1);
            push(ALU, 1'b1, 1'b1);
         end
         push(ALU_LAST, 1'b0, 1'b1);
         push(ALU_LAST, 1'b1, 1'b1);
      end
      push(EXEC, 1'b0, 1'b1);
      push(EXEC, 1'b1, 1'b1);
   endtask

   task automatic sample_pop(output obs_t got, output obs_t want);
      #1;
      got = obs_t'({s3, s2, s1, s0, ws, running});
      if (sb.size() > 0) want = sb.pop_front();
      else               want = 'x;
   endtask

   task automatic test_reset;
      obs_t g, w;
      rst = 1'b1; run = 1'b1; step = 1'b1; deref = 1'b0; o0 = 1'b0; o1 = 1'b0; o2 = 1'b0;
      @(negedge clk);
      step = 1'b0;
      #1;
      checks++;
      if ({s3, s2, s1, s0} !== 4'b0000) begin
         failures++; $display("FAIL reset_state: got %b required 0000", {s3, s2, s1, s0});
      end
      checks++;
      if (ws !== 1'b0) begin failures++; $display("FAIL reset_ws: got %b required 0", ws); end
      checks++;
      if (running !== 1'b0) begin failures++; $display("FAIL reset_running: got %b required 0", running); end
      @(negedge clk);
      rst = 1'b0; run = 1'b0;
      for (int i = 0; i < 3; i++) push(FETCH, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         sample_pop(g, w);
         checks++;
         if (g !== w) begin
            failures++;
            $display("FAIL reset_hold[%0d]: got s=%b ws=%b running=%b required s=%b ws=%b running=%b",
                     i, g.s, g.ws, g.rn, w.s, w.ws, w.rn);
         end
         @(negedge clk);
      end
      $display("tb: reset and idle hold done");
   endtask

   task automatic test_short;
      obs_t g, w;
      int n;
      run = 1'b1; o2 = 1'b1; deref = 1'b0;
      push_instr(1'b1, 1'b0, 1'b1);
      push(FETCH, 1'b0, 1'b0);
      push(FETCH, 1'b0, 1'b0);
      n = sb.size();
      for (int i = 0; i < n; i++) begin
         if (i == 3) run = 1'b0;
         sample_pop(g, w);
         checks++;
         if (g !== w) begin
            failures++;
            $display("FAIL short[%0d]: got s=%b ws=%b running=%b required s=%b ws=%b running=%b",
                     i, g.s, g.ws, g.rn, w.s, w.ws, w.rn);
         end
         @(negedge clk);
      end
      $display("tb: o2=1 deref=0 instruction done");
   endtask

   task automatic test_long;
      obs_t g, w;
      int n;
      int ws_alu;
      ws_alu = 0;
      run = 1'b1; o2 = 1'b0; deref = 1'b1;
      push_instr(1'b0, 1'b1, 1'b1);
      push(FETCH, 1'b0, 1'b0);
      push(FETCH, 1'b0, 1'b0);
      n = sb.size();
      for (int i = 0; i < n; i++) begin
         if (i == 2) begin deref = 1'b0; o2 = 1'b1; end
         if (i == 23) run = 1'b0;
         sample_pop(g, w);
         if (g.ws === 1'b1 && (g.s === ALU || g.s === ALU_LAST)) ws_alu++;
         checks++;
         if (g !== w) begin
            failures++;
            $display("FAIL long[%0d]: got s=%b ws=%b running=%b required s=%b ws=%b running=%b",
                     i, g.s, g.ws, g.rn, w.s, w.ws, w.rn);
         end
         @(negedge clk);
      end
      checks++;
      if (ws_alu != 8) begin
         failures++; $display("FAIL alu_ws_pulses: got %0d required 8", ws_alu);
      end
      $display("tb: o2=0 deref=1 instruction done (inputs changed after sample)");
   endtask

   task automatic test_run_drop;
      obs_t g, w;
      int n;
      run = 1'b1; o2 = 1'b0; deref = 1'b0;
      push_instr(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) push(FETCH, 1'b0, 1'b0);
      n = sb.size();
      for (int i = 0; i < n; i++) begin
         if (i == 2) run = 1'b0;
         sample_pop(g, w);
         checks++;
         if (g !== w) begin
            failures++;
            $display("FAIL run_drop[%0d]: got s=%b ws=%b running=%b required s=%b ws=%b running=%b",
                     i, g.s, g.ws, g.rn, w.s, w.ws, w.rn);
         end
         @(negedge clk);
      end
      $display("tb: run dropped in LOAD, instruction completed");
   endtask

   task automatic test_step;
      obs_t g, w;
      int n;
      // Single step from idle: pulse latches, then one instruction.
      run = 1'b0; o2 = 1'b1; deref = 1'b0;
      push(FETCH, 1'b0, 1'b0);
      push_instr(1'b1, 1'b0, 1'b0);
      push(FETCH, 1'b0, 1'b0);
      n = sb.size();
      for (int i = 0; i < n; i++) begin
         step = (i == 0);
         sample_pop(g, w);
         checks++;
         if (g !== w) begin
            failures++;
            $display("FAIL step_idle[%0d]: got s=%b ws=%b running=%b required s=%b ws=%b running=%b",
                     i, g.s, g.ws, g.rn, w.s, w.ws, w.rn);
         end
         @(negedge clk);
      end
      // Two pulses three cycles apart while stopped mid-instruction: one extra instruction only.
      run = 1'b1; o2 = 1'b0; deref = 1'b0;
      push_instr(1'b0, 1'b0, 1'b1);
      push_instr(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) push(FETCH, 1'b0, 1'b0);
      n = sb.size();
      for (int i = 0; i < n; i++) begin
         if (i == 2) run = 1'b0;
         step = (i == 6) || (i == 9);
         if (i == 10) o2 = 1'b1;
         sample_pop(g, w);
         checks++;
         if (g !== w) begin
            failures++;
            $display("FAIL step_double[%0d]: got s=%b ws=%b running=%b required s=%b ws=%b running=%b",
                     i, g.s, g.ws, g.rn, w.s, w.ws, w.rn);
         end
         @(negedge clk);
      end
      $display("tb: step instructions done");
   endtask

   task automatic test_reset_mid_alu;
      obs_t g, w;
      run = 1'b1; o2 = 1'b0; deref = 1'b0;
      push_instr(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 11; i++) begin
         sample_pop(g, w);
         checks++;
         if (g !== w) begin
            failures++;
            $display("FAIL pre_reset[%0d]: got s=%b ws=%b running=%b required s=%b ws=%b running=%b",
                     i, g.s, g.ws, g.rn, w.s, w.ws, w.rn);
         end
         @(negedge clk);
      end
      sb.delete();
      // Now in ALU phase 1 with the bit counter at 3.
      rst = 1'b1;
      #1;
      checks++;
      if ({s3, s2, s1, s0, ws, running} !== 6'b000000) begin
         failures++;
         $display("FAIL mid_alu_reset: got s=%b ws=%b running=%b required s=0000 ws=0 running=0",
                  {s3, s2, s1, s0}, ws, running);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0; run = 1'b0;
      for (int i = 0; i < 3; i++) push(FETCH, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         sample_pop(g, w);
         checks++;
         if (g !== w) begin
            failures++;
            $display("FAIL post_reset[%0d]: got s=%b ws=%b running=%b required s=%b ws=%b running=%b",
                     i, g.s, g.ws, g.rn, w.s, w.ws, w.rn);
         end
         @(negedge clk);
      end
      $display("tb: reset during ALU done");
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_short();
      test_long();
      test_run_drop();
      test_step();
      test_reset_mid_alu();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/q2_sequencer.md
Q2_SEQUENCER -- requirements
Module: q2_sequencer

Interface
REQ-001 SHALL have: clk  in  1  system clock; all state changes on rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: run  in  1  level; 1 = execute continuously.
REQ-004 SHALL have: step  in  1  single-cycle pulse; execute one instruction while stopped.
REQ-005 SHALL have: deref  in  1  indirect-address flag from the fetched opcode.
REQ-006 SHALL have: o0, o1, o2  in  1 each  opcode bits; o2=0 selects an ALU instruction.
REQ-007 SHALL have: s0, s1, s2, s3  out  1 each  state code consumed by the control decoder.
REQ-008 SHALL have: ws  out  1  write strobe; high in the second phase of each state.
REQ-009 SHALL have: running  out  1  high while an instruction is in progress or run=1 is being honoured.

Function
REQ-010 SHALL encode states as s3 s2 s1 s0:
- FETCH=0000
- DEREF=0001
- LOAD=0010
- EXEC=0011
- ALU=0100
- ALU_LAST=1100
REQ-011 SHALL give every state two phases of one clock each:
- phase 0: ws=0
- phase 1: ws=1
REQ-012 SHALL leave a state only on the edge that ends phase 1; ws SHALL never be high for two consecutive cycles.
REQ-013 SHALL sample deref, o0, o1 and o2 on the edge that ends FETCH phase 1; those samples SHALL drive all branch decisions for the instruction.
REQ-014 SHALL transition from FETCH as follows:
- deref=1 -> DEREF
- else o2=0 -> LOAD
- else EXEC
REQ-015 SHALL transition from DEREF as follows:
- o2=0 -> LOAD
- else EXEC
REQ-016 SHALL transition from LOAD to ALU and clear a 3-bit bit counter to 0.
REQ-017 SHALL, in ALU, increment the bit counter at the end of each phase 1.
- counter 0..5: remain in ALU
- counter 6: enter ALU_LAST
REQ-018 SHALL make the bit-serial operation last exactly 8 ws pulses: 7 in ALU plus 1 in ALU_LAST.
REQ-019 SHALL transition from ALU_LAST to EXEC, and from EXEC to FETCH.
REQ-020 SHALL give per-instruction latency in cycles:
- o2=1, deref=0: 4
- o2=1, deref=1: 6
- o2=0, deref=0: 22
- o2=0, deref=1: 24
REQ-021 SHALL evaluate run/stop only at FETCH phase 0.
- run=1 or a pending step: proceed to phase 1
- otherwise: hold FETCH phase 0 with ws=0
REQ-022 SHALL latch a step pulse into a pending flag at any time; the flag SHALL clear when FETCH phase 1 is entered.
- a second pulse before the clear SHALL be ignored
REQ-023 SHALL always let an instruction already past FETCH phase 0 complete, even if run drops mid-instruction.
REQ-024 SHALL drive running=1 from FETCH phase 1 through the end of EXEC phase 1, and also whenever run=1.
REQ-025 SHALL hold the bit counter at its value outside ALU states.
REQ-026 SHALL force any unused state code to FETCH phase 0 on the next edge.

Reset
REQ-027 SHALL, while rst=1, immediately drive:
- state=FETCH, phase 0
- s0..s3=0, ws=0, running=0
- bit counter=0
- pending step cleared
REQ-028 SHALL abandon any instruction in progress when rst asserts, without completing it.
REQ-029 SHALL, after rst deasserts, remain in FETCH phase 0 until run=1 or step.

Verification
REQ-030 Reset mid-ALU: assert rst while the counter is 3 -> same cycle s=0000, ws=0; holds with run=0.
REQ-031 run=1, o2=1, deref=0 -> state sequence FETCH, FETCH, EXEC, EXEC; ws pattern 0101; back to FETCH at cycle 4.
REQ-032 run=1, o2=0, deref=1 -> FETCH, DEREF, LOAD, then ALU for 14 cycles, ALU_LAST for 2, EXEC for 2; exactly 8 ws pulses in ALU/ALU_LAST; total 24 cycles.
REQ-033 run=0, two step pulses 3 cycles apart while stopped -> exactly one instruction runs, then the sequencer holds FETCH phase 0 with running=0.
REQ-034 run dropped during LOAD (o2=0) -> instruction completes through EXEC, then the sequencer halts at FETCH phase 0.
REQ-035 deref/o2 changed after the FETCH sample edge -> path unchanged; branch decisions follow the sampled values only.
